pe_acc_window: RTL and testbench

Temporal window accumulator placed directly downstream of the 16-input PE adder tree. It consumes the tree's final-level result one beat at a time and sums a programmable number of beats into a wide accumulator. Each window total is right-shifted, saturated to ACC_BW, and presented on a one-entry output buffer with a valid/ready handshake. Accumulation of the next window proceeds while the previous result waits in the buffer; backpressure reaches the tree side only when a second result would overwrite an undrained one.

---
 rtl/pe_acc_window.sv | 139 +++++++++++++
 tb/tb_pe_acc_window.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_acc_window.sv
// Windowed accumulator behind the PE adder tree: sums L beats, shifts, saturates to ACC_BW.
// Latency: result registered on the edge that accepts the window's last beat (visible next cycle).
// Backpressure: only a completing beat stalls, and only while an undrained result occupies the buffer.
module pe_acc_window #(
  parameter int ACC_BW = 32,
  parameter int CNT_BW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ACC_BW-1:0] in_data,
  input  logic [CNT_BW-1:0] cfg_len,
  input  logic [4:0]        cfg_shift,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_BW-1:0] out_data,
  output logic              out_ovf
);

  // Wide enough for (2^CNT_BW - 1) beats of ACC_BW bits, so the sum never wraps.
  localparam int SUM_BW = ACC_BW + CNT_BW;

  // Window state
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic [SUM_BW-1:0] acc_q, acc_d;
  logic [CNT_BW-1:0] len_q, len_d;
  logic [4:0]        shift_q, shift_d;

  // One-entry output buffer
  logic              out_valid_q, out_valid_d;
  logic [ACC_BW-1:0] out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;

  // Datapath helpers
  logic              first_beat;
  logic [CNT_BW-1:0] eff_len;
  logic              last_beat;
  logic              accept;
  logic              drain;
  logic [SUM_BW-1:0] sum_w;
  logic [4:0]        shamt;
  logic [SUM_BW-1:0] shifted;
  logic              sat;

  // A window's config comes from the live cfg inputs on its first beat, from the latched copy afterwards.
  always_comb begin
    first_beat = (cnt_q == '0);
    if (first_beat) begin
      eff_len = (cfg_len == '0) ? CNT_BW'(1) : cfg_len;
      shamt   = cfg_shift;
    end else begin
      eff_len = len_q;
      shamt   = shift_q;
    end
    last_beat = (cnt_q == (eff_len - CNT_BW'(1)));
  end

  // Handshakes: a completing beat may proceed if the buffer is empty or is draining this cycle.
  always_comb begin
    in_ready = !clear && !(last_beat && out_valid_q && !out_ready);
    accept   = in_valid && in_ready;
    drain    = out_valid_q && out_ready;
  end

  // Window sum including the current beat, then logical shift and saturation check.
  always_comb begin
    sum_w   = (first_beat ? {SUM_BW{1'b0}} : acc_q) + {{CNT_BW{1'b0}}, in_data};
    shifted = sum_w >> shamt;
    sat     = |shifted[SUM_BW-1:ACC_BW];
  end

  // Next-state for the accumulator, counter and latched window configuration.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    len_d   = len_q;
    shift_d = shift_q;
    if (clear) begin
      // Abort the in-progress window; the output buffer is left alone.
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      if (last_beat) begin
        cnt_d = '0;
        acc_d = '0;
      end else if (first_beat) begin
        cnt_d   = CNT_BW'(1);
        acc_d   = sum_w;
        len_d   = cfg_len;
        shift_d = cfg_shift;
      end else begin
        cnt_d = cnt_q + CNT_BW'(1);
        acc_d = sum_w;
      end
    end
  end

  // Next-state for the output buffer: a completion reloads it (even while draining), a bare drain empties it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (accept && last_beat) begin
      out_valid_d = 1'b1;
      out_ovf_d   = sat;
      out_data_d  = sat ? {ACC_BW{1'b1}} : shifted[ACC_BW-1:0];
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_pe_acc_window.sv
// Scoreboarded bench for pe_acc_window: expected results queued at issue, popped on each drain.
module tb_pe_acc_window;

  localparam int ACC_BW = 32;
  localparam int CNT_BW = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [ACC_BW-1:0] in_data;
  logic [CNT_BW-1:0] cfg_len;
  logic [4:0]        cfg_shift;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_BW-1:0] out_data;
  logic              out_ovf;

  int checks;
  int failures;

  // Expected results: {ovf, data}
  logic [ACC_BW:0] sb_q[$];

  pe_acc_window #(.ACC_BW(ACC_BW), .CNT_BW(CNT_BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cfg_len   (cfg_len),
    .cfg_shift (cfg_shift),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic [ACC_BW-1:0] d, input logic ovf);
    sb_q.push_back({ovf, d});
  endtask

  // Present one beat and hold it until accepted; returns with in_valid low, 1ns after the accepting edge.
  task automatic send(input logic [ACC_BW-1:0] d, output int stalls);
    bit done;
    stalls = 0;
    done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (in_ready) done = 1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      failures++;
      checks++;
      $display("FAIL send_timeout: beat 0x%0h never accepted", d);
    end
  endtask

  // Monitor: every drained result is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got data 0x%0h ovf %0d, none expected", out_data, out_ovf);
      end else begin
        logic [ACC_BW:0] e;
        e = sb_q.pop_front();
        check("result_data", {32'd0, out_data}, {32'd0, e[ACC_BW-1:0]});
        check("result_ovf", {63'd0, out_ovf}, {63'd0, e[ACC_BW]});
      end
    end
  end

  initial begin
    int st;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_len   = 8'd1;
    cfg_shift = 5'd0;
    clear     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Partial window of length 5 (cnt=3), then reset mid-window
    cfg_len = 8'd5;
    send(32'd100, st);
    send(32'd100, st);
    send(32'd100, st);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_data", {32'd0, out_data}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic window: (10+20+30+40)>>2 = 25, valid for exactly one cycle
    cfg_len   = 8'd4;
    cfg_shift = 5'd2;
    send(32'd10, st);
    send(32'd20, st);
    send(32'd30, st);
    expect_result(32'd25, 1'b0);
    send(32'd40, st);
    check("basic_valid", {63'd0, out_valid}, 64'd1);
    check("basic_data", {32'd0, out_data}, 64'd25);
    @(posedge clk);
    #1;
    check("basic_valid_drop", {63'd0, out_valid}, 64'd0);

    // Saturation: 0xFFFFFFFF + 2 exceeds 32 bits
    cfg_len   = 8'd2;
    cfg_shift = 5'd0;
    send(32'hFFFF_FFFF, st);
    expect_result(32'hFFFF_FFFF, 1'b1);
    send(32'h0000_0002, st);
    check("sat_ovf", {63'd0, out_ovf}, 64'd1);
    check("sat_data", {32'd0, out_data}, 64'h0000_0000_FFFF_FFFF);
    @(posedge clk);
    #1;

    // Backpressure with L=1
    out_ready = 1'b0;
    cfg_len   = 8'd1;
    expect_result(32'd5, 1'b0);
    send(32'd5, st);
    check("bp_first_no_stall", st, 64'd0);
    check("bp_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b1;
    in_data  = 32'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      check("bp_hold_data", {32'd0, out_data}, 64'd5);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    expect_result(32'd7, 1'b0);
    #1;
    check("bp_in_ready_drain", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_reload_valid", {63'd0, out_valid}, 64'd1);
    check("bp_reload_data", {32'd0, out_data}, 64'd7);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Config latching: len 3 captured at first beat, later change ignored
    cfg_len = 8'd3;
    send(32'd1, st);
    cfg_len = 8'd1;
    send(32'd2, st);
    expect_result(32'd6, 1'b0);
    send(32'd3, st);
    check("latch_data", {32'd0, out_data}, 64'd6);

    // Clear discards the 9s; the next window of 4s totals 12
    cfg_len = 8'd3;
    send(32'd9, st);
    send(32'd9, st);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd9;
    #1;
    check("clear_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    send(32'd4, st);
    send(32'd4, st);
    expect_result(32'd12, 1'b0);
    send(32'd4, st);
    check("clear_data", {32'd0, out_data}, 64'd12);

    // Length 0 acts as 1; drain and completion overlap every cycle
    cfg_len = 8'd0;
    expect_result(32'd1, 1'b0);
    expect_result(32'd2, 1'b0);
    expect_result(32'd3, 1'b0);
    send(32'd1, st);
    check("len0_stall_1", st, 64'd0);
    send(32'd2, st);
    check("len0_stall_2", st, 64'd0);
    check("len0_valid_2", {63'd0, out_valid}, 64'd1);
    send(32'd3, st);
    check("len0_stall_3", st, 64'd0);
    check("len0_valid_3", {63'd0, out_valid}, 64'd1);
    check("len0_data_3", {32'd0, out_data}, 64'd3);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
